// File: rtl/peripheral_wb_burst_master.sv
// Wishbone B4 burst master: accepts one read or write command, runs it as a
// registered-feedback burst (linear or wrapping), then pulses done_o/err_o.
module peripheral_wb_burst_master #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int LW = 4
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_ni,
   input  logic          cmd_valid_i,
   output logic          cmd_ready_o,
   input  logic          cmd_we_i,
   input  logic [AW-1:0] cmd_adr_i,
   input  logic [LW-1:0] cmd_len_i,
   input  logic [1:0]    cmd_bte_i,
   input  logic          wdat_valid_i,
   output logic          wdat_ready_o,
   input  logic [DW-1:0] wdat_i,
   output logic          rdat_valid_o,
   output logic [DW-1:0] rdat_o,
   output logic          done_o,
   output logic          err_o,
   output logic          wb_cyc_o,
   output logic          wb_stb_o,
   output logic          wb_we_o,
   output logic [AW-1:0] wb_adr_o,
   output logic [DW-1:0] wb_dat_o,
   output logic [DW/8-1:0] wb_sel_o,
   output logic [2:0]    wb_cti_o,
   output logic [1:0]    wb_bte_o,
   input  logic [DW-1:0] wb_dat_i,
   input  logic          wb_ack_i,
   input  logic          wb_err_i
);

   localparam int SW = DW / 8;
   localparam int OB = $clog2(SW);
   localparam logic [AW-1:0] STEP = AW'(SW);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        state, state_next;
   logic          we_q, held_q, err_q, rdat_valid_q;
   logic [AW-1:0] adr_q, adr_next, adr_inc, wrap_mask;
   logic [LW-1:0] len_q, cnt_q;
   logic [1:0]    bte_q;
   logic [DW-1:0] wdat_q, rdat_q;
   logic          accept, beat_ack, beat_err, load_wdat;
   int            wrap_bits;

   assign accept    = cmd_valid_i & cmd_ready_o;
   assign beat_err  = wb_cyc_o & wb_stb_o & wb_err_i;
   assign beat_ack  = wb_cyc_o & wb_stb_o & wb_ack_i & ~wb_err_i;
   assign load_wdat = wdat_valid_i & wdat_ready_o;

   // Wrapping bursts only advance the low bits covering n beats; the rest of
   // the address stays pinned to the aligned block the burst started in.
   always_comb begin
      adr_inc = adr_q + STEP;
      case (bte_q)
         2'd1:    wrap_bits = OB + 2;
         2'd2:    wrap_bits = OB + 3;
         default: wrap_bits = OB + 4;
      endcase
      wrap_mask = ~({AW{1'b1}} << wrap_bits);
      if (bte_q == 2'd0) adr_next = adr_inc;
      else               adr_next = (adr_q & ~wrap_mask) | (adr_inc & wrap_mask);
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) state <= IDLE;
      else            state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = BUSY;
         BUSY: if (beat_err || (beat_ack && cnt_q == '0)) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Bus outputs are gated by BUSY so reset drops the cycle asynchronously.
   always_comb begin
      cmd_ready_o  = (state == IDLE) & wb_rst_ni;
      wb_cyc_o     = (state == BUSY);
      wb_stb_o     = (state == BUSY) & (~we_q | held_q);
      wb_we_o      = (state == BUSY) & we_q;
      wdat_ready_o = (state == BUSY) & we_q & ~held_q;
      wb_adr_o     = '0;
      wb_dat_o     = '0;
      wb_sel_o     = '0;
      wb_cti_o     = 3'b000;
      wb_bte_o     = 2'b00;
      if (state == BUSY) begin
         wb_adr_o = adr_q;
         wb_dat_o = we_q ? wdat_q : '0;
         wb_sel_o = {SW{1'b1}};
         wb_bte_o = bte_q;
         if (len_q == '0)      wb_cti_o = 3'b000;
         else if (cnt_q == '0) wb_cti_o = 3'b111;
         else                  wb_cti_o = 3'b010;
      end
      done_o = (state == DONE);
      err_o  = (state == DONE) & err_q;
   end

   assign rdat_valid_o = rdat_valid_q;
   assign rdat_o       = rdat_q;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         we_q         <= 1'b0;
         held_q       <= 1'b0;
         err_q        <= 1'b0;
         rdat_valid_q <= 1'b0;
         adr_q        <= '0;
         len_q        <= '0;
         cnt_q        <= '0;
         bte_q        <= 2'b00;
         wdat_q       <= '0;
         rdat_q       <= '0;
      end else begin
         rdat_valid_q <= 1'b0;
         if (accept) begin
            we_q   <= cmd_we_i;
            adr_q  <= cmd_adr_i;
            len_q  <= cmd_len_i;
            cnt_q  <= cmd_len_i;
            bte_q  <= cmd_bte_i;
            held_q <= 1'b0;
            err_q  <= 1'b0;
         end
         if (load_wdat) begin
            wdat_q <= wdat_i;
            held_q <= 1'b1;
         end
         if (beat_ack) begin
            cnt_q  <= cnt_q - 1'b1;
            adr_q  <= adr_next;
            held_q <= 1'b0;
            if (!we_q) begin
               rdat_q       <= wb_dat_i;
               rdat_valid_q <= 1'b1;
            end
         end
         if (beat_err) err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_peripheral_wb_burst_master.sv
// Directed bench for peripheral_wb_burst_master: linear/wrap reads, delayed
// write data, error abort, mid-burst reset and address wrap-around.
module tb_peripheral_wb_burst_master;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_ni;
   logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
   logic [31:0] cmd_adr_i;
   logic [3:0]  cmd_len_i;
   logic [1:0]  cmd_bte_i;
   logic        wdat_valid_i, wdat_ready_o;
   logic [31:0] wdat_i;
   logic        rdat_valid_o;
   logic [31:0] rdat_o;
   logic        done_o, err_o;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic [31:0] wb_adr_o, wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic [2:0]  wb_cti_o;
   logic [1:0]  wb_bte_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i, wb_err_i;

   int passCount = 0;
   int checkCount = 0;
   int rvCount = 0;
   int doneCount = 0;
   int rvBase, doneBase;
   logic [31:0] expAdr [16];

   peripheral_wb_burst_master #(.AW(32), .DW(32), .LW(4)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
      .cmd_adr_i(cmd_adr_i), .cmd_len_i(cmd_len_i), .cmd_bte_i(cmd_bte_i),
      .wdat_valid_i(wdat_valid_i), .wdat_ready_o(wdat_ready_o), .wdat_i(wdat_i),
      .rdat_valid_o(rdat_valid_o), .rdat_o(rdat_o), .done_o(done_o), .err_o(err_o),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
      .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
      .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   // Pulse counters sampled mid-cycle, away from the active edge.
   always @(negedge wb_clk_i) begin
      if (rdat_valid_o) rvCount++;
      if (done_o) doneCount++;
   end

   task automatic tick;
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic applyStimulus(input logic we, input logic [31:0] adr,
                                input logic [3:0] len, input logic [1:0] bte);
      checkOutput("cmd_ready_idle", cmd_ready_o, 1);
      cmd_we_i    = we;
      cmd_adr_i   = adr;
      cmd_len_i   = len;
      cmd_bte_i   = bte;
      cmd_valid_i = 1'b1;
      tick;
      cmd_valid_i = 1'b0;
      checkOutput("cmd_ready_busy", cmd_ready_o, 0);
   endtask

   task automatic runRead(input logic [31:0] adr, input logic [3:0] len, input logic [1:0] bte);
      logic [2:0] expCti;
      rvBase = rvCount;
      wb_ack_i = 1'b1;
      applyStimulus(1'b0, adr, len, bte);
      for (int i = 0; i <= int'(len); i++) begin
         if (len == 4'd0)          expCti = 3'b000;
         else if (i == int'(len))  expCti = 3'b111;
         else                      expCti = 3'b010;
         checkOutput("rd_cyc", wb_cyc_o, 1);
         checkOutput("rd_stb", wb_stb_o, 1);
         checkOutput("rd_adr", wb_adr_o, expAdr[i]);
         checkOutput("rd_cti", wb_cti_o, expCti);
         checkOutput("rd_bte", wb_bte_o, bte);
         if (i > 0) begin
            checkOutput("rd_valid", rdat_valid_o, 1);
            checkOutput("rd_data", rdat_o, 32'hD000_0000 + 32'(i - 1));
         end
         wb_dat_i = 32'hD000_0000 + 32'(i);
         tick;
      end
      checkOutput("rd_done", done_o, 1);
      checkOutput("rd_err", err_o, 0);
      checkOutput("rd_cyc_done", wb_cyc_o, 0);
      checkOutput("rd_valid_last", rdat_valid_o, 1);
      checkOutput("rd_data_last", rdat_o, 32'hD000_0000 + 32'(len));
      tick;
      checkOutput("rd_done_pulse", done_o, 0);
      checkOutput("rd_ready_back", cmd_ready_o, 1);
      checkOutput("rd_valid_count", rvCount - rvBase, int'(len) + 1);
      wb_ack_i = 1'b0;
   endtask

   initial begin
      wb_rst_ni = 1'b0;
      cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = '0; cmd_len_i = '0; cmd_bte_i = '0;
      wdat_valid_i = 1'b0; wdat_i = '0; wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;

      #12;
      checkOutput("rst_cyc", wb_cyc_o, 0);
      checkOutput("rst_stb", wb_stb_o, 0);
      checkOutput("rst_adr", wb_adr_o, 0);
      checkOutput("rst_done", done_o, 0);
      checkOutput("rst_wdat_ready", wdat_ready_o, 0);
      checkOutput("rst_rdat", rdat_o, 0);
      wb_rst_ni = 1'b1;
      tick;
      checkOutput("rst_cmd_ready", cmd_ready_o, 1);

      $display("[TB] linear read");
      expAdr[0] = 32'h100; expAdr[1] = 32'h104; expAdr[2] = 32'h108; expAdr[3] = 32'h10C;
      runRead(32'h100, 4'd3, 2'd0);

      $display("[TB] wrap4 read");
      expAdr[0] = 32'h0C; expAdr[1] = 32'h00; expAdr[2] = 32'h04; expAdr[3] = 32'h08;
      runRead(32'h0C, 4'd3, 2'd1);

      $display("[TB] single write, delayed data");
      wb_ack_i = 1'b1;
      applyStimulus(1'b1, 32'h200, 4'd0, 2'd0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("wr_cyc_wait", wb_cyc_o, 1);
         checkOutput("wr_stb_wait", wb_stb_o, 0);
         checkOutput("wr_ready_wait", wdat_ready_o, 1);
         tick;
      end
      wdat_i = 32'hCAFE_F00D;
      wdat_valid_i = 1'b1;
      tick;
      wdat_valid_i = 1'b0;
      checkOutput("wr_stb", wb_stb_o, 1);
      checkOutput("wr_we", wb_we_o, 1);
      checkOutput("wr_ready_held", wdat_ready_o, 0);
      checkOutput("wr_cti", wb_cti_o, 3'b000);
      checkOutput("wr_dat", wb_dat_o, 32'hCAFE_F00D);
      checkOutput("wr_sel", wb_sel_o, 4'hF);
      checkOutput("wr_adr", wb_adr_o, 32'h200);
      tick;
      checkOutput("wr_done", done_o, 1);
      checkOutput("wr_err", err_o, 0);
      checkOutput("wr_cyc_done", wb_cyc_o, 0);
      tick;
      wb_ack_i = 1'b0;

      $display("[TB] read aborted by err on third beat");
      rvBase = rvCount;
      wb_ack_i = 1'b1;
      applyStimulus(1'b0, 32'h400, 4'd7, 2'd0);
      wb_dat_i = 32'h1111_0000;
      tick;
      wb_dat_i = 32'h1111_0001;
      tick;
      checkOutput("err_adr_beat3", wb_adr_o, 32'h408);
      wb_err_i = 1'b1;
      tick;
      wb_err_i = 1'b0;
      checkOutput("err_done", done_o, 1);
      checkOutput("err_flag", err_o, 1);
      checkOutput("err_cyc", wb_cyc_o, 0);
      checkOutput("err_no_valid", rdat_valid_o, 0);
      tick;
      checkOutput("err_valid_count", rvCount - rvBase, 2);
      checkOutput("err_ready_back", cmd_ready_o, 1);

      $display("[TB] reset during 16-beat burst");
      doneBase = doneCount;
      applyStimulus(1'b0, 32'h300, 4'd15, 2'd0);
      tick;
      checkOutput("rb_adr_beat2", wb_adr_o, 32'h304);
      checkOutput("rb_cyc_beat2", wb_cyc_o, 1);
      #2 wb_rst_ni = 1'b0;
      #1;
      checkOutput("rb_cyc_async", wb_cyc_o, 0);
      checkOutput("rb_stb_async", wb_stb_o, 0);
      checkOutput("rb_adr_async", wb_adr_o, 0);
      checkOutput("rb_valid_async", rdat_valid_o, 0);
      #3 wb_rst_ni = 1'b1;
      tick;
      tick;
      checkOutput("rb_ready_after", cmd_ready_o, 1);
      checkOutput("rb_cyc_after", wb_cyc_o, 0);
      checkOutput("rb_no_done", doneCount - doneBase, 0);
      wb_ack_i = 1'b0;

      $display("[TB] linear address wrap-around");
      expAdr[0] = 32'hFFFF_FFFC; expAdr[1] = 32'h0000_0000;
      runRead(32'hFFFF_FFFC, 4'd1, 2'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   initial begin
      #50000;
      $display("[TB] FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/peripheral_wb_burst_master.md
PERIPHERAL_WB_BURST_MASTER -- requirements
Module: peripheral_wb_burst_master

Interface
REQ-001 SHALL have parameter AW, default 32, Wishbone address width.
REQ-002 SHALL have parameter DW, default 32, Wishbone data width (power of 2, >=8).
REQ-003 SHALL have parameter LW, default 4, burst-length field width; max burst = 2^LW beats.
REQ-004 SHALL have ports, clock and reset first, in this order:
- wb_clk_i, in, 1, sole clock; all state updates on its rising edge.
- wb_rst_ni, in, 1, reset, asynchronous, active-low.
- cmd_valid_i, in, 1, command request.
- cmd_ready_o, out, 1, command accepted when valid & ready.
- cmd_we_i, in, 1, 0 = READ, 1 = WRITE.
- cmd_adr_i, in, AW, start byte address, DW/8-aligned.
- cmd_len_i, in, LW, beats minus 1.
- cmd_bte_i, in, 2, LINEAR=0, WRAP_4=1, WRAP_8=2, WRAP_16=3.
- wdat_valid_i / wdat_ready_o, in / out, 1 each, write-data handshake.
- wdat_i, in, DW, write data.
- rdat_valid_o, out, 1, one-cycle read-data strobe, no backpressure.
- rdat_o, out, DW, read data.
- done_o, out, 1, one-cycle end-of-command pulse.
- err_o, out, 1, valid with done_o; 1 = burst terminated by wb_err_i.
- wb_cyc_o, wb_stb_o, wb_we_o, out, 1 each.
- wb_adr_o, out, AW; wb_dat_o, out, DW; wb_sel_o, out, DW/8 (all ones).
- wb_cti_o, out, 3; wb_bte_o, out, 2.
- wb_dat_i, in, DW; wb_ack_i, in, 1; wb_err_i, in, 1.

Function
REQ-005 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-006 IDLE: cmd_ready_o=1; on accept, latch we, adr, len, bte, load beat counter = len, go BUSY next cycle.
REQ-007 BUSY: wb_cyc_o=1; wb_stb_o=1 for reads; for writes wb_stb_o = beat data held.
REQ-008 Write beat data SHALL be loaded from wdat_i when wdat_valid_i & wdat_ready_o.
REQ-009 wdat_ready_o=1 only in BUSY with we=1 and no beat data held.
REQ-010 A beat SHALL complete on the edge where cyc & stb & ack.
REQ-011 On read beat completion, rdat_o = wb_dat_i and rdat_valid_o=1 in the following cycle.
REQ-012 On each completed beat, the beat counter SHALL decrement and wb_adr_o SHALL advance by DW/8.
REQ-013 Address advance rule by mode:
- LINEAR: plain increment, AW-bit wrap-around.
- WRAP_n: only the low log2(n)+log2(DW/8) bits increment, modulo n beats; upper bits fixed.
REQ-014 wb_cti_o rules:
- 3'b000 (CLASSIC) when len=0.
- otherwise 3'b010 (INC_BURST) on every beat except the last.
- 3'b111 (END_OF_BURST) on the last beat (counter=0).
REQ-015 wb_bte_o SHALL equal the latched bte during BUSY, else 0.
REQ-016 Last-beat completion SHALL go to DONE, deasserting cyc/stb in the same edge.
REQ-017 wb_err_i with cyc & stb SHALL abort the burst: go DONE with err flag set; no rdat_valid_o for that beat.
REQ-018 DONE SHALL last one cycle: done_o=1, err_o = flag; then IDLE.
REQ-019 ack and err asserted together SHALL be treated as err.
REQ-020 Latency: command accept to first wb_stb_o (read) = 1 cycle; last ack to done_o = 1 cycle.
REQ-021 cmd_ready_o SHALL be 0 outside IDLE; commands are never queued.

Reset
REQ-022 While wb_rst_ni=0, immediately:
- state = IDLE.
- all wb_* outputs 0; rdat_o 0; rdat_valid_o, done_o, err_o, wdat_ready_o 0.
- cmd_ready_o 1 once released.
REQ-023 Reset mid-burst SHALL drop cyc/stb asynchronously and discard the burst with no done_o.

Verification
REQ-024 Read, adr=0x100, len=3, LINEAR, ack every cycle -> adr 0x100, 0x104, 0x108, 0x10C; cti 010,010,010,111; four rdat_valid_o; done_o, err_o=0.
REQ-025 Read, adr=0x0C, len=3, WRAP_4 -> adr 0x0C, 0x00, 0x04, 0x08; bte=1.
REQ-026 Write, len=0, wdat_valid_i delayed 3 cycles -> stb low until data held; one beat, cti=000; wb_dat_o = wdat_i.
REQ-027 Read, len=7, wb_err_i on beat 3 -> cyc drops; 2 rdat_valid_o; done_o with err_o=1.
REQ-028 wb_rst_ni low during beat 2 of a 16-beat burst -> cyc/stb 0 immediately; no done_o; cmd_ready_o=1 after release.
REQ-029 LINEAR, adr=0xFFFFFFFC, len=1 -> second adr = 0x00000000.
